vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Upstream stage of the ball/sprite renderers: generates 640x480@60 VGA timing from the 25 MHz pixel clock.
- Outputs: beam position (hpos/vpos), sync pulses, display_on.
- Also provides single-cycle line_start/frame_start strobes and a frame counter, so downstream motion logic updates once per frame in the clk domain instead of clocking off vsync edges.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels); H_TOTAL = sum = 800
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines); V_TOTAL = sum = 525

Ports:
- clk  in  1  pixel clock (25 MHz)
- res  in  1  asynchronous reset, active-low
- pix_en  in  1  pixel advance enable; tie high for 1 pixel/clk
- hpos  out  10  current column, 0..H_TOTAL-1
- vpos  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- display_on  out  1  high when hpos<H_DISPLAY and vpos<V_DISPLAY
- line_start  out  1  one-clk strobe on entering hpos=0
- frame_start  out  1  one-clk strobe on entering hpos=0,vpos=0
- frame_cnt  out  16  frames started since reset, wraps

Behaviour:
- All outputs are registered and mutually coherent: hsync, vsync and display_on always describe the hpos/vpos values presented in the same cycle. Flags are computed from next-state counters.
- Reset (res=0, async) forces:
  - hpos=H_TOTAL-1, vpos=V_TOTAL-1 (last pixel of frame)
  - hsync=vsync=inactive, display_on=0
  - line_start=frame_start=0, frame_cnt=0
- Advance: on a clk edge with res=1 and pix_en=1:
  - hpos increments.
  - At hpos=H_TOTAL-1, hpos wraps to 0 and vpos increments.
  - At vpos=V_TOTAL-1 with that wrap, vpos wraps to 0.
- First advance after reset release lands on (0,0) with frame_start=1, line_start=1, frame_cnt=1.
- pix_en=0: all counters and level outputs hold. line_start/frame_start are 0 on every cycle that did not advance, so each strobe lasts exactly one clk regardless of pix_en duty.
- hsync active iff H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC (656..751 default).
- vsync active iff V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC (490..491 default); vsync is line-based, changing only together with the hpos wrap.
- Sync polarity is active-low unless the optional feature is enabled.
- frame_cnt increments in the same edge frame_start is set; wraps 0xFFFF->0x0000 without any flag.
- Counter widths are 10 bits; parameter sets with H_TOTAL or V_TOTAL >1024 are unsupported.
- Reset mid-frame: immediate async return to reset values; the next frame restarts cleanly at (0,0).

Optional Feature:
- Macro: VGA_SYNC_POS_EN
- Defined: hsync/vsync are active-high, and their reset/inactive level is 0.
- Undefined (default): active-low, and their reset/inactive level is 1.
- Timing positions are identical in both builds.

Test Plan:
- Reset release, pix_en=1 -> first edge: hpos=0, vpos=0, frame_start=1, line_start=1, frame_cnt=1, display_on=1, hsync=vsync=1 (low-active build).
- Run one line -> hsync=0 exactly for hpos 656..751 (96 clks); display_on=0 from hpos 640; hpos 799->0 increments vpos, line_start pulses once per 800 clks.
- Run full frame -> vsync=0 exactly for vpos 490..491 (1600 clks); frame_start period 420000 clks; frame_cnt=2 at second frame start.
- pix_en toggled 1,0 alternately -> counters advance every other clk; line_start/frame_start high for 1 clk only; frame period 840000 clks.
- Assert res at hpos=300, vpos=200 -> outputs immediately at reset values; after release, frame restarts at (0,0) with frame_cnt=1.
- Build with VGA_SYNC_POS_EN -> hsync=1 for hpos 656..751, vsync=1 for vpos 490..491, both 0 during reset.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Beam-position bus between the VGA timing generator and the renderers.
// master = timing generator, slave = downstream consumer that owns pix_en.
interface vga_timing_gen_if;
    logic        pix_en;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        hsync;
    logic        vsync;
    logic        display_on;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_cnt;

    modport master (
        input  pix_en,
        output hpos, vpos, hsync, vsync, display_on,
               line_start, frame_start, frame_cnt
    );

    modport slave (
        output pix_en,
        input  hpos, vpos, hsync, vsync, display_on,
               line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator with per-line/per-frame strobes and a frame counter.
// Define VGA_SYNC_POS_EN for active-high hsync/vsync (default build is active-low).
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic               clk,
    input  logic               res,
    vga_timing_gen_if.master   bus
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

`ifdef VGA_SYNC_POS_EN
    localparam logic SYNC_ON = 1'b1;
`else
    localparam logic SYNC_ON = 1'b0;
`endif

    logic [9:0]  r_hpos;
    logic [9:0]  r_vpos;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_displayOn;
    logic        r_lineStart;
    logic        r_frameStart;
    logic [15:0] r_frameCnt;

    logic        w_hWrap;
    logic        w_vWrap;
    logic [9:0]  w_hNext;
    logic [9:0]  w_vNext;

    assign w_hWrap = (r_hpos == H_LAST);
    assign w_vWrap = (r_vpos == V_LAST);
    assign w_hNext = w_hWrap ? 10'd0 : r_hpos + 10'd1;
    assign w_vNext = w_hWrap ? (w_vWrap ? 10'd0 : r_vpos + 10'd1) : r_vpos;

    // Level outputs are derived from the next counter values so they line up
    // with the hpos/vpos presented in the same cycle.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_hpos       <= H_LAST;
            r_vpos       <= V_LAST;
            r_hsync      <= ~SYNC_ON;
            r_vsync      <= ~SYNC_ON;
            r_displayOn  <= 1'b0;
            r_lineStart  <= 1'b0;
            r_frameStart <= 1'b0;
            r_frameCnt   <= 16'd0;
        end else if (bus.pix_en) begin
            r_hpos       <= w_hNext;
            r_vpos       <= w_vNext;
            r_hsync      <= (w_hNext >= HS_START && w_hNext < HS_END) ? SYNC_ON : ~SYNC_ON;
            r_vsync      <= (w_vNext >= VS_START && w_vNext < VS_END) ? SYNC_ON : ~SYNC_ON;
            r_displayOn  <= (w_hNext < H_VIS) && (w_vNext < V_VIS);
            r_lineStart  <= w_hWrap;
            r_frameStart <= w_hWrap && w_vWrap;
            if (w_hWrap && w_vWrap) begin
                r_frameCnt <= r_frameCnt + 16'd1;
            end
        end else begin
            r_lineStart  <= 1'b0;
            r_frameStart <= 1'b0;
        end
    end

    assign bus.hpos        = r_hpos;
    assign bus.vpos        = r_vpos;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.display_on  = r_displayOn;
    assign bus.line_start  = r_lineStart;
    assign bus.frame_start = r_frameStart;
    assign bus.frame_cnt   = r_frameCnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default-size instance for reset and line timing,
// and a reduced-size instance (35x21 totals) so whole frames fit in a short run.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_POS_EN
    localparam logic ACT   = 1'b1;
    localparam logic INACT = 1'b0;
`else
    localparam logic ACT   = 1'b0;
    localparam logic INACT = 1'b1;
`endif

    logic clk = 1'b0;
    logic resA;
    logic resB;
    int   nChecks = 0;
    int   nFails  = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if busA();
    vga_timing_gen_if busB();

    vga_timing_gen dutA (
        .clk (clk),
        .res (resA),
        .bus (busA.master)
    );

    // Small set: H 20+4+6+5=35 (hsync 24..29), V 12+3+2+4=21 (vsync 15..16)
    vga_timing_gen #(
        .H_DISPLAY(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
        .V_DISPLAY(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(4)
    ) dutB (
        .clk (clk),
        .res (resB),
        .bus (busB.master)
    );

    task automatic test_reset;
        resA = 1'b0;
        resB = 1'b0;
        busA.pix_en = 1'b1;
        busB.pix_en = 1'b1;
        repeat (3) @(negedge clk);
        nChecks++; if (busA.hpos !== 10'd799) begin nFails++; $display("[TB] FAIL reset_hpos: got %0d expected 799", busA.hpos); end
        nChecks++; if (busA.vpos !== 10'd524) begin nFails++; $display("[TB] FAIL reset_vpos: got %0d expected 524", busA.vpos); end
        nChecks++; if (busA.hsync !== INACT) begin nFails++; $display("[TB] FAIL reset_hsync: got %b expected %b", busA.hsync, INACT); end
        nChecks++; if (busA.vsync !== INACT) begin nFails++; $display("[TB] FAIL reset_vsync: got %b expected %b", busA.vsync, INACT); end
        nChecks++; if (busA.display_on !== 1'b0) begin nFails++; $display("[TB] FAIL reset_display_on: got %b expected 0", busA.display_on); end
        nChecks++; if (busA.line_start !== 1'b0) begin nFails++; $display("[TB] FAIL reset_line_start: got %b expected 0", busA.line_start); end
        nChecks++; if (busA.frame_start !== 1'b0) begin nFails++; $display("[TB] FAIL reset_frame_start: got %b expected 0", busA.frame_start); end
        nChecks++; if (busA.frame_cnt !== 16'd0) begin nFails++; $display("[TB] FAIL reset_frame_cnt: got %0d expected 0", busA.frame_cnt); end
        nChecks++; if (busB.hpos !== 10'd34 || busB.vpos !== 10'd20) begin nFails++; $display("[TB] FAIL reset_small_pos: got (%0d,%0d) expected (34,20)", busB.hpos, busB.vpos); end
    endtask

    task automatic test_first_advance;
        resA = 1'b1;
        @(negedge clk);
        nChecks++; if (busA.hpos !== 10'd0 || busA.vpos !== 10'd0) begin nFails++; $display("[TB] FAIL first_pos: got (%0d,%0d) expected (0,0)", busA.hpos, busA.vpos); end
        nChecks++; if (busA.frame_start !== 1'b1) begin nFails++; $display("[TB] FAIL first_frame_start: got %b expected 1", busA.frame_start); end
        nChecks++; if (busA.line_start !== 1'b1) begin nFails++; $display("[TB] FAIL first_line_start: got %b expected 1", busA.line_start); end
        nChecks++; if (busA.frame_cnt !== 16'd1) begin nFails++; $display("[TB] FAIL first_frame_cnt: got %0d expected 1", busA.frame_cnt); end
        nChecks++; if (busA.display_on !== 1'b1) begin nFails++; $display("[TB] FAIL first_display_on: got %b expected 1", busA.display_on); end
        nChecks++; if (busA.hsync !== INACT || busA.vsync !== INACT) begin nFails++; $display("[TB] FAIL first_sync: got h=%b v=%b expected %b", busA.hsync, busA.vsync, INACT); end
    endtask

    task automatic test_line;
        int   hsCount;
        logic expHs;
        logic expDe;
        hsCount = 0;
        for (int i = 0; i < 800; i++) begin
            expHs = (i >= 656 && i < 752) ? ACT : INACT;
            expDe = (i < 640);
            nChecks++; if (busA.hpos !== 10'(i) || busA.vpos !== 10'd0) begin nFails++; $display("[TB] FAIL line_pos: got (%0d,%0d) expected (%0d,0)", busA.hpos, busA.vpos, i); end
            nChecks++; if (busA.hsync !== expHs) begin nFails++; $display("[TB] FAIL line_hsync at h=%0d: got %b expected %b", i, busA.hsync, expHs); end
            nChecks++; if (busA.display_on !== expDe) begin nFails++; $display("[TB] FAIL line_display_on at h=%0d: got %b expected %b", i, busA.display_on, expDe); end
            nChecks++; if (busA.line_start !== (i == 0)) begin nFails++; $display("[TB] FAIL line_strobe at h=%0d: got %b expected %b", i, busA.line_start, (i == 0)); end
            if (busA.hsync === ACT) hsCount++;
            @(negedge clk);
        end
        nChecks++; if (hsCount !== 96) begin nFails++; $display("[TB] FAIL line_hsync_width: got %0d expected 96", hsCount); end
        nChecks++; if (busA.hpos !== 10'd0 || busA.vpos !== 10'd1) begin nFails++; $display("[TB] FAIL line_wrap_pos: got (%0d,%0d) expected (0,1)", busA.hpos, busA.vpos); end
        nChecks++; if (busA.line_start !== 1'b1 || busA.frame_start !== 1'b0) begin nFails++; $display("[TB] FAIL line_wrap_strobes: got ls=%b fs=%b expected ls=1 fs=0", busA.line_start, busA.frame_start); end
    endtask

    task automatic test_frame;
        int   vsCount;
        int   expH;
        int   expV;
        logic expHs;
        logic expVs;
        logic expDe;
        vsCount = 0;
        resB = 1'b1;
        @(negedge clk);
        nChecks++; if (busB.frame_cnt !== 16'd1) begin nFails++; $display("[TB] FAIL frame_cnt_first: got %0d expected 1", busB.frame_cnt); end
        for (int i = 0; i < 735; i++) begin
            expH  = i % 35;
            expV  = i / 35;
            expHs = (expH >= 24 && expH < 30) ? ACT : INACT;
            expVs = (expV >= 15 && expV < 17) ? ACT : INACT;
            expDe = (expH < 20) && (expV < 12);
            nChecks++; if (busB.hpos !== 10'(expH) || busB.vpos !== 10'(expV)) begin nFails++; $display("[TB] FAIL frame_pos: got (%0d,%0d) expected (%0d,%0d)", busB.hpos, busB.vpos, expH, expV); end
            nChecks++; if (busB.hsync !== expHs) begin nFails++; $display("[TB] FAIL frame_hsync at (%0d,%0d): got %b expected %b", expH, expV, busB.hsync, expHs); end
            nChecks++; if (busB.vsync !== expVs) begin nFails++; $display("[TB] FAIL frame_vsync at (%0d,%0d): got %b expected %b", expH, expV, busB.vsync, expVs); end
            nChecks++; if (busB.display_on !== expDe) begin nFails++; $display("[TB] FAIL frame_display_on at (%0d,%0d): got %b expected %b", expH, expV, busB.display_on, expDe); end
            nChecks++; if (busB.line_start !== (expH == 0)) begin nFails++; $display("[TB] FAIL frame_line_start at (%0d,%0d): got %b", expH, expV, busB.line_start); end
            nChecks++; if (busB.frame_start !== (i == 0)) begin nFails++; $display("[TB] FAIL frame_frame_start at (%0d,%0d): got %b", expH, expV, busB.frame_start); end
            if (busB.vsync === ACT) vsCount++;
            @(negedge clk);
        end
        nChecks++; if (vsCount !== 70) begin nFails++; $display("[TB] FAIL frame_vsync_width: got %0d expected 70", vsCount); end
        nChecks++; if (busB.hpos !== 10'd0 || busB.vpos !== 10'd0 || busB.frame_start !== 1'b1) begin nFails++; $display("[TB] FAIL frame_second_start: got (%0d,%0d) fs=%b expected (0,0) fs=1", busB.hpos, busB.vpos, busB.frame_start); end
        nChecks++; if (busB.frame_cnt !== 16'd2) begin nFails++; $display("[TB] FAIL frame_cnt_second: got %0d expected 2", busB.frame_cnt); end
    endtask

    task automatic test_pix_en_toggle;
        int   expH;
        int   expV;
        int   expCnt;
        int   fsCount;
        int   lsCount;
        logic en;
        logic expLs;
        logic expFs;
        expH = 0;
        expV = 0;
        expCnt = 2;
        fsCount = 0;
        lsCount = 0;
        for (int i = 0; i < 1470; i++) begin
            en = (i % 2 == 1);
            busB.pix_en = en;
            @(negedge clk);
            if (en) begin
                expH = expH + 1;
                if (expH == 35) begin
                    expH = 0;
                    expV = (expV == 20) ? 0 : expV + 1;
                end
                expLs = (expH == 0);
                expFs = expLs && (expV == 0);
                if (expFs) expCnt++;
            end else begin
                expLs = 1'b0;
                expFs = 1'b0;
            end
            nChecks++; if (busB.hpos !== 10'(expH) || busB.vpos !== 10'(expV)) begin nFails++; $display("[TB] FAIL toggle_pos at i=%0d: got (%0d,%0d) expected (%0d,%0d)", i, busB.hpos, busB.vpos, expH, expV); end
            nChecks++; if (busB.line_start !== expLs || busB.frame_start !== expFs) begin nFails++; $display("[TB] FAIL toggle_strobes at i=%0d: got ls=%b fs=%b expected ls=%b fs=%b", i, busB.line_start, busB.frame_start, expLs, expFs); end
            nChecks++; if (busB.frame_cnt !== 16'(expCnt)) begin nFails++; $display("[TB] FAIL toggle_frame_cnt at i=%0d: got %0d expected %0d", i, busB.frame_cnt, expCnt); end
            if (busB.frame_start === 1'b1) fsCount++;
            if (busB.line_start === 1'b1) lsCount++;
        end
        nChecks++; if (fsCount !== 1) begin nFails++; $display("[TB] FAIL toggle_frame_strobe_count: got %0d expected 1", fsCount); end
        nChecks++; if (lsCount !== 21) begin nFails++; $display("[TB] FAIL toggle_line_strobe_count: got %0d expected 21", lsCount); end
        nChecks++; if (busB.frame_cnt !== 16'd3) begin nFails++; $display("[TB] FAIL toggle_frame_cnt_end: got %0d expected 3", busB.frame_cnt); end
    endtask

    task automatic test_mid_frame_reset;
        busB.pix_en = 1'b1;
        repeat (258) @(negedge clk);
        nChecks++; if (busB.hpos !== 10'd13 || busB.vpos !== 10'd7 || busB.display_on !== 1'b1) begin nFails++; $display("[TB] FAIL midreset_pre_pos: got (%0d,%0d) de=%b expected (13,7) de=1", busB.hpos, busB.vpos, busB.display_on); end
        @(posedge clk);
        #2 resB = 1'b0;
        #1;
        nChecks++; if (busB.hpos !== 10'd34 || busB.vpos !== 10'd20) begin nFails++; $display("[TB] FAIL midreset_async_pos: got (%0d,%0d) expected (34,20)", busB.hpos, busB.vpos); end
        nChecks++; if (busB.frame_cnt !== 16'd0 || busB.display_on !== 1'b0) begin nFails++; $display("[TB] FAIL midreset_async_cnt_de: got cnt=%0d de=%b expected cnt=0 de=0", busB.frame_cnt, busB.display_on); end
        nChecks++; if (busB.hsync !== INACT || busB.vsync !== INACT) begin nFails++; $display("[TB] FAIL midreset_async_sync: got h=%b v=%b expected %b", busB.hsync, busB.vsync, INACT); end
        repeat (3) @(negedge clk);
        nChecks++; if (busB.hpos !== 10'd34 || busB.line_start !== 1'b0 || busB.frame_start !== 1'b0) begin nFails++; $display("[TB] FAIL midreset_hold: got h=%0d ls=%b fs=%b expected h=34 ls=0 fs=0", busB.hpos, busB.line_start, busB.frame_start); end
        resB = 1'b1;
        @(negedge clk);
        nChecks++; if (busB.hpos !== 10'd0 || busB.vpos !== 10'd0) begin nFails++; $display("[TB] FAIL midreset_restart_pos: got (%0d,%0d) expected (0,0)", busB.hpos, busB.vpos); end
        nChecks++; if (busB.frame_start !== 1'b1 || busB.line_start !== 1'b1) begin nFails++; $display("[TB] FAIL midreset_restart_strobes: got fs=%b ls=%b expected 1 1", busB.frame_start, busB.line_start); end
        nChecks++; if (busB.frame_cnt !== 16'd1) begin nFails++; $display("[TB] FAIL midreset_restart_cnt: got %0d expected 1", busB.frame_cnt); end
    endtask

    initial begin
        $display("[TB] vga_timing_gen directed test starting");
        test_reset();
        test_first_advance();
        test_line();
        test_frame();
        test_pix_en_toggle();
        test_mid_frame_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
